// File: rtl/biu_slave_if.sv
// Device-side handshake of the bus interface unit: strobe, captured request
// fields, and the device's read-data return path.
interface biu_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  en;
  logic [ADDR_WIDTH-1:0] address;
  logic                  rnw;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  busy;
  logic                  error;

  modport slave  (output en, address, rnw, data_out, busy, error,
                  input  data_in, data_valid);
  modport master (input  en, address, rnw, data_out, busy, error,
                  output data_in, data_valid);
endinterface

// File: rtl/biu_slave.sv
// Responder end of the shared single-master bus: decodes a one-cycle request,
// strobes the local device, and answers reads (or times out with ERR_DATA).
module biu_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN  = 'h1000,
  parameter int                    TIMEOUT    = 16,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  n_rst,
  inout  wire  [ADDR_WIDTH-1:0] bus_address_io,
  inout  wire  [DATA_WIDTH-1:0] bus_data_io,
  inout  wire  [1:0]            bus_control_io,
  biu_slave_if.slave            biu
);
  localparam logic [4:0] IDLE     = 5'b00001;
  localparam logic [4:0] ACCESS   = 5'b00010;
  localparam logic [4:0] WAIT_DEV = 5'b00100;
  localparam logic [4:0] RESPOND  = 5'b01000;
  localparam logic [4:0] OBSERVE  = 5'b10000;

  localparam logic [8:0] TO_LIM  = 9'(TIMEOUT);
  localparam logic [8:0] OBS_LIM = 9'(TIMEOUT + 2);

  logic [4:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rnw_q, rnw_d;
  logic                  err_q, err_d;
  logic [8:0]            cnt_q, cnt_d;

  logic                  req, hit, drive;
  logic [ADDR_WIDTH-1:0] offset;

  // Modulo subtraction makes one unsigned compare cover both window edges.
  assign offset = bus_address_io - BASE_ADDR;
  assign hit    = (offset < ADDR_SPAN);
  assign req    = bus_control_io[0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rnw_d   = rnw_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            addr_d  = bus_address_io;
            data_d  = bus_data_io;
            rnw_d   = bus_control_io[1];
            err_d   = 1'b0;
            state_d = ACCESS;
          end else if (bus_control_io[1]) begin
            cnt_d   = 9'd1;
            state_d = OBSERVE;
          end
        end
      end
      ACCESS: begin
        cnt_d = 9'd1;
        if (!rnw_q) begin
          state_d = IDLE;
        end else if (biu.data_valid) begin
          data_d  = biu.data_in;
          state_d = RESPOND;
        end else begin
          state_d = WAIT_DEV;
        end
      end
      WAIT_DEV: begin
        if (biu.data_valid) begin
          data_d  = biu.data_in;
          state_d = RESPOND;
        end else if (cnt_q + 9'd1 >= TO_LIM) begin
          data_d  = ERR_DATA;
          err_d   = 1'b1;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      RESPOND: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      // Another slave owns this read; wait out its response window.
      OBSERVE: begin
        if (req || cnt_q >= OBS_LIM) state_d = IDLE;
        else                         cnt_d   = cnt_q + 9'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rnw_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rnw_q   <= rnw_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign drive          = (state_q == RESPOND);
  assign bus_address_io = drive ? addr_q : 'z;
  assign bus_data_io    = drive ? data_q : 'z;
  assign bus_control_io = drive ? 2'b11  : 'z;

  assign biu.en       = (state_q == ACCESS);
  assign biu.address  = addr_q - BASE_ADDR;
  assign biu.rnw      = rnw_q;
  assign biu.data_out = data_q;
  assign biu.busy     = (state_q != IDLE);
  assign biu.error    = drive & err_q;
endmodule

// File: tb/tb_biu_slave.sv
// Two responders (0x0000 and 0x1000) on one bus; a latency model derived from
// the request/response timing rules predicts every strobe and response.
module tb_biu_slave;
  localparam int          TO  = 16;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  wire  [31:0] bus_addr, bus_data;
  wire  [1:0]  bus_ctl;
  logic        m_oe;
  logic [31:0] m_addr, m_data;
  logic [1:0]  m_ctl;

  assign bus_addr = m_oe ? m_addr : 'z;
  assign bus_data = m_oe ? m_data : 'z;
  assign bus_ctl  = m_oe ? m_ctl  : 'z;

  biu_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
  biu_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if1 ();

  biu_slave #(.BASE_ADDR(32'h0000), .ADDR_SPAN(32'h1000), .TIMEOUT(TO), .ERR_DATA(ERR)) dut0 (
    .clk(clk), .n_rst(n_rst), .bus_address_io(bus_addr), .bus_data_io(bus_data),
    .bus_control_io(bus_ctl), .biu(if0.slave));
  biu_slave #(.BASE_ADDR(32'h1000), .ADDR_SPAN(32'h1000), .TIMEOUT(TO), .ERR_DATA(ERR)) dut1 (
    .clk(clk), .n_rst(n_rst), .bus_address_io(bus_addr), .bus_data_io(bus_data),
    .bus_control_io(bus_ctl), .biu(if1.slave));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_rel(input logic [31:0] v);
    return $isunknown(v) || (v == 32'd0);
  endfunction

  function automatic bit released();
    return is_rel(bus_addr) && is_rel(bus_data) && is_rel(32'(bus_ctl));
  endfunction

  // One bus transaction; delay = cycles after the strobe that the target device
  // raises data_valid (>= TO means too late, i.e. a timeout is expected).
  task automatic txn(input logic [31:0] addr, input bit rnw, input logic [31:0] wdata,
                     input int delay, input logic [31:0] ddata);
    int tgt, rc, ncyc;
    bit ok;
    logic [31:0] base;
    tgt  = (addr < 32'h1000) ? 0 : (addr < 32'h2000) ? 1 : 2;
    base = (tgt == 1) ? 32'h1000 : 32'h0;
    ok   = (delay < TO);
    rc   = (rnw && tgt < 2) ? (ok ? 2 + delay : 1 + TO) : -1;
    ncyc = rnw ? TO + 4 : 2;
    for (int k = 0; k < ncyc; k++) begin
      m_oe = (k == 0); m_addr = addr; m_data = wdata; m_ctl = {rnw, 1'b1};
      if0.data_in    = (tgt == 0) ? ddata : $urandom();
      if1.data_in    = (tgt == 1) ? ddata : $urandom();
      if0.data_valid = (tgt == 0) && (k == 1 + delay);
      if1.data_valid = (tgt == 1) && (k == 1 + delay);
      @(negedge clk);
      chk("en0", 32'(if0.en), 32'((tgt == 0) && (k == 1)));
      chk("en1", 32'(if1.en), 32'((tgt == 1) && (k == 1)));
      if (k == 1 && tgt < 2) begin
        chk("offset", (tgt == 0) ? if0.address : if1.address, addr - base);
        chk("rnw", 32'((tgt == 0) ? if0.rnw : if1.rnw), 32'(rnw));
        chk("busy", 32'((tgt == 0) ? if0.busy : if1.busy), 32'd1);
        if (!rnw) chk("wdata", (tgt == 0) ? if0.data_out : if1.data_out, wdata);
      end
      if (k > 0) begin
        chk("err0", 32'(if0.error), 32'(k == rc && tgt == 0 && !ok));
        chk("err1", 32'(if1.error), 32'(k == rc && tgt == 1 && !ok));
        if (k == rc) begin
          chk("resp_ctl",  32'(bus_ctl), 32'h3);
          chk("resp_data", bus_data, ok ? ddata : ERR);
          chk("resp_addr", bus_addr, addr);
        end else begin
          chk("released", 32'(released()), 32'd1);
        end
      end
      @(posedge clk); #1;
    end
    m_oe = 1'b0; if0.data_valid = 1'b0; if1.data_valid = 1'b0;
    chk("idle0", 32'(if0.busy), 32'd0);
    chk("idle1", 32'(if1.busy), 32'd0);
  endtask

  // Read to dut0, then pull reset asynchronously in cycle kstop of the request.
  task automatic reset_at(input int kstop, input int delay, input bit expect_drive);
    for (int k = 0; k <= kstop; k++) begin
      m_oe = (k == 0); m_addr = 32'h10; m_data = 32'h0; m_ctl = 2'b11;
      if0.data_in = 32'h600DF00D; if0.data_valid = (k == 1 + delay);
      if (k < kstop) begin @(posedge clk); #1; end
    end
    #1;
    chk("pre_busy", 32'(if0.busy), 32'd1);
    if (expect_drive) chk("pre_drive", 32'(bus_ctl), 32'h3);
    #1; n_rst = 1'b0; #1;
    chk("rst_en",    32'(if0.en),    32'd0);
    chk("rst_busy",  32'(if0.busy),  32'd0);
    chk("rst_err",   32'(if0.error), 32'd0);
    chk("rst_busy1", 32'(if1.busy),  32'd0);
    chk("rst_rel",   32'(released()), 32'd1);
    if0.data_valid = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    n_rst = 1'b0; m_oe = 1'b0; m_addr = '0; m_data = '0; m_ctl = '0;
    if0.data_in = '0; if0.data_valid = 1'b0;
    if1.data_in = '0; if1.data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_en",   32'(if0.en),    32'd0);
    chk("reset_busy", 32'(if0.busy),  32'd0);
    chk("reset_err",  32'(if0.error), 32'd0);
    chk("reset_rel",  32'(released()), 32'd1);
    n_rst = 1'b1;

    txn(32'h0000_0004, 1'b0, 32'h12345678, 0,   32'h0);
    txn(32'h0000_0008, 1'b1, 32'h0,        0,   32'hA5A5A5A5);
    txn(32'h0000_0020, 1'b1, 32'h0,        3,   32'h3C3C1234);
    txn(32'h0000_0030, 1'b1, 32'h0,        100, 32'h11112222);
    txn(32'h0000_0034, 1'b1, 32'h0,        TO - 1, 32'h0BADCAFE);
    txn(32'h0000_0038, 1'b1, 32'h0,        TO, 32'h0BADCAFF);
    txn(32'h0000_1004, 1'b1, 32'h0,        1,   32'hCAFE0001);
    txn(32'h0000_0FFC, 1'b1, 32'h0,        2,   32'h0FFC0FFC);
    txn(32'h0000_1000, 1'b0, 32'h87654321, 0,   32'h0);
    txn(32'h0000_0040, 1'b0, 32'h00000055, 0,   32'h0);
    txn(32'h0000_0044, 1'b1, 32'h0,        0,   32'h00000077);
    txn(32'h0000_3000, 1'b1, 32'h0,        0,   32'h0);
    txn(32'h0000_2000, 1'b0, 32'h99,       0,   32'h0);

    reset_at(3, 100, 1'b0);
    txn(32'h0000_0100, 1'b1, 32'h0, 0, 32'h13579BDF);
    reset_at(2, 0, 1'b1);
    txn(32'h0000_1100, 1'b1, 32'h0, 4, 32'h2468ACE0);

    repeat (40) begin
      a = $urandom_range(0, 32'h2FFF) & ~32'h3;
      txn(a, 1'($urandom_range(0, 1)), $urandom(), $urandom_range(0, TO + 2), $urandom());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
